button_debounce_events: RTL



---
 rtl/button_debounce_events.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_debounce_events.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and
// registered press / release / long-press event pulses with a wrapping
// press counter.
module button_debounce_events #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);

  // The edge that leaves a stable state has already seen one changed sample
  // of s2, so the debounce count starts at 1 and the change is accepted on
  // the DB_CYCLES-th consecutive changed sample.
  localparam logic [DbW-1:0]   DbFirst  = DbW'(1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldPrev = HoldW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q;
  logic             s1_q;
  logic             s2_q;
  logic [DbW-1:0]   db_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;

  // Bring the asynchronous pin into the clock domain; only s2 is used below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM with registered level, event pulses and press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s2_q) begin
            state_q  <= StPressWait;
            db_cnt_q <= DbFirst;
          end
        end
        StPressWait: begin
          if (!s2_q) begin
            state_q <= StIdle;
          end else if (db_cnt_q == DbLast) begin
            state_q     <= StPressed;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + CNT_W'(1);
            hold_cnt_q  <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        StPressed: begin
          // Saturating hold count; the long pulse fires only on the step
          // into saturation, so it is issued once per press.
          if (hold_cnt_q != HoldLast) begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
            if (hold_cnt_q == HoldPrev) begin
              long_pulse <= 1'b1;
            end
          end
          if (!s2_q) begin
            state_q  <= StReleaseWait;
            db_cnt_q <= DbFirst;
          end
        end
        StReleaseWait: begin
          // hold_cnt_q is frozen here and kept if the release was a bounce.
          if (s2_q) begin
            state_q <= StPressed;
          end else if (db_cnt_q == DbLast) begin
            state_q       <= StIdle;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
